keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 168 ++++++++++++++++
 tb/tb_keypad_emulator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: emulates a 4x4 hex keypad behind a column-scanning matrix
// reader. A command presses one key for a given number of complete scan
// frames, then holds all rows released for REL_FRAMES frames before
// signalling done.
// Optional feature macro: KYPD_BOUNCE_EN adds contact chatter for the first
// BOUNCE_CYC clocks after the key is pressed and after it is released.
module keypad_emulator #(
  parameter int HOLD_W     = 8,
  parameter int REL_FRAMES = 2,
  parameter int BOUNCE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        Col,
  output logic [3:0]        Row,
  input  logic [3:0]        key,
  input  logic [HOLD_W-1:0] hold,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              abort,
  output logic              busy,
  output logic              done
);

  // One counter serves both the press and the release phase, so it must be
  // wide enough for whichever count is larger.
  localparam int REL_W = $clog2(REL_FRAMES + 1);
  localparam int CNT_W = (HOLD_W > REL_W) ? HOLD_W : REL_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] REL_LAST = (REL_FRAMES > 0) ? CNT_W'(REL_FRAMES - 1) : '0;

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

  state_t            state_reg;
  logic [3:0]        col_reg;
  logic [3:0]        key_reg;
  logic [HOLD_W-1:0] hold_reg;
  logic [CNT_W-1:0]  frame_cnt_reg;

  logic             accept;
  logic             frame_start;
  logic [CNT_W-1:0] hold_eff;
  logic             press_end;
  logic             rel_end;
  logic             press_next;
  logic             release_next;
  logic [3:0]       key_sel;
  logic             key_on;
  logic [3:0]       row_next;

  // Column code (active-low) that scans the given key.
  function automatic logic [3:0] key_col(input logic [3:0] k);
    case (k)
      4'h1, 4'h4, 4'h7, 4'h0: key_col = 4'b0111;
      4'h2, 4'h5, 4'h8, 4'hF: key_col = 4'b1011;
      4'h3, 4'h6, 4'h9, 4'hE: key_col = 4'b1101;
      default:                key_col = 4'b1110;  // A, B, C, D
    endcase
  endfunction

  // Row code (active-low) the given key pulls low when its column is driven.
  function automatic logic [3:0] key_row(input logic [3:0] k);
    case (k)
      4'h1, 4'h2, 4'h3, 4'hA: key_row = 4'b0111;
      4'h4, 4'h5, 4'h6, 4'hB: key_row = 4'b1011;
      4'h7, 4'h8, 4'h9, 4'hC: key_row = 4'b1101;
      default:                key_row = 4'b1110;  // 0, F, E, D
    endcase
  endfunction

`ifdef KYPD_BOUNCE_EN
  localparam int BW = $clog2(BOUNCE_CYC + 2);
  logic [BW-1:0] bounce_cnt_reg;
  logic [BW-1:0] bounce_cnt_next;
  logic          chatter;

  // Clocks since the last press/release entry; restarts on every entry.
  always_comb begin
    if (accept || press_end)
      bounce_cnt_next = '0;
    else if (bounce_cnt_reg < BW'(BOUNCE_CYC))
      bounce_cnt_next = bounce_cnt_reg + 1'b1;
    else
      bounce_cnt_next = bounce_cnt_reg;
    chatter = (bounce_cnt_next < BW'(BOUNCE_CYC));
    // During the window the contact alternates pressed/released each clock.
    if (press_next)
      key_on = !chatter || !bounce_cnt_next[0];
    else
      key_on = release_next && chatter && !bounce_cnt_next[0];
  end

  // Chatter window counter.
  always_ff @(posedge clk) begin
    if (!rst_n) bounce_cnt_reg <= '0;
    else        bounce_cnt_reg <= bounce_cnt_next;
  end
`else
  // Clean contact: the key is closed for exactly the press phase.
  always_comb key_on = press_next;
`endif

  // Next-state decisions; Row is computed from the next state so that the
  // key lets go on the very edge that leaves PRESS.
  always_comb begin
    accept       = (state_reg == IDLE) && cmd_valid && cmd_ready;
    frame_start  = (Col == 4'b0111) && (col_reg != 4'b0111);
    hold_eff     = (hold_reg == '0) ? CNT_W'(1) : CNT_W'(hold_reg);
    press_end    = (state_reg == PRESS) &&
                   (abort || (frame_start && (frame_cnt_reg == hold_eff)));
    rel_end      = (state_reg == RELEASE) && frame_start && (frame_cnt_reg == REL_LAST);
    press_next   = accept || ((state_reg == PRESS) && !press_end);
    release_next = press_end || ((state_reg == RELEASE) && !rel_end);
    key_sel      = accept ? key : key_reg;
    // A non-one-hot Col never equals a key column, so it always reads released.
    row_next     = (key_on && (Col == key_col(key_sel))) ? key_row(key_sel) : 4'b1111;
  end

  // Command FSM with registered outputs and the saturating frame counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      col_reg       <= 4'b1111;
      key_reg       <= '0;
      hold_reg      <= '0;
      frame_cnt_reg <= '0;
      Row           <= 4'b1111;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      col_reg   <= Col;
      Row       <= row_next;
      done      <= rel_end;
      busy      <= press_next || release_next;
      // Ready returns one cycle after done, never in the same cycle.
      cmd_ready <= (state_reg == IDLE) && !accept;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg     <= PRESS;
            key_reg       <= key;
            hold_reg      <= hold;
            frame_cnt_reg <= '0;
          end
        end
        PRESS: begin
          if (press_end) begin
            state_reg     <= RELEASE;
            frame_cnt_reg <= '0;
          end else if (frame_start && (frame_cnt_reg != CNT_MAX)) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
          end
        end
        RELEASE: begin
          if (rel_end) begin
            state_reg     <= IDLE;
            frame_cnt_reg <= '0;
          end else if (frame_start && (frame_cnt_reg != CNT_MAX)) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed, table-driven bench for keypad_emulator
// (default build, REL_FRAMES = 2, short scan columns of COL_CYC clocks).
module tb_keypad_emulator;

  localparam int COL_CYC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] Col;
  logic [3:0] Row;
  logic [3:0] key;
  logic [7:0] hold;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       abort;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int done_total = 0;

  typedef struct {
    logic [3:0] key;
    logic [3:0] col;
    logic [3:0] row;
  } vec_t;

  vec_t       vecs[22];
  logic [3:0] cols[4];

  keypad_emulator #(.HOLD_W(8), .REL_FRAMES(2), .BOUNCE_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .Col(Col), .Row(Row), .key(key), .hold(hold),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .abort(abort),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Count every done pulse seen on a rising edge.
  always @(posedge clk) if (done === 1'b1) done_total++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic press_cmd(input logic [3:0] k, input logic [7:0] h, input logic [3:0] c);
    int n;
    n = 0;
    Col = c;
    while (cmd_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_timeout: got %b expected 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    key = k;
    hold = h;
    tick();
    cmd_valid = 1'b0;
    check_val("press_busy", int'(busy), 1);
  endtask

  // Abort the current press and walk two frame starts by hand.
  task automatic abort_release(input string name);
    abort = 1'b1;
    Col = 4'b1111;
    tick();
    abort = 1'b0;
    check_val({name, "_abort_row"}, int'(Row), 4'b1111);
    Col = 4'b0111; tick();
    Col = 4'b1011; tick();
    Col = 4'b0111; tick();
    check_val({name, "_done"}, int'(done), 1);
    check_val({name, "_rdy_lo"}, int'(cmd_ready), 0);
    tick();
    check_val({name, "_rdy_hi"}, int'(cmd_ready), 1);
  endtask

  // Full-speed scan; counts Row hits on the key's column, stray row activity,
  // and where done / cmd_ready show up (cycle index from the first frame).
  task automatic run_scan(input int frames, input logic [3:0] kcol, input logic [3:0] krow,
                          input int abort_at, output int hits, output int stray,
                          output int dones, output int done_idx, output int rdy_at_done,
                          output int rdy_after, output int row_at_abort);
    int idx;
    idx = 0;
    hits = 0; stray = 0; dones = 0; done_idx = -1;
    rdy_at_done = -1; rdy_after = -1; row_at_abort = -1;
    for (int f = 0; f < frames; f++) begin
      for (int c = 0; c < 4; c++) begin
        for (int k = 0; k < COL_CYC; k++) begin
          Col = cols[c];
          abort = (idx == abort_at);
          tick();
          abort = 1'b0;
          if (Row == krow && Col == kcol) hits++;
          else if (Row != 4'b1111) stray++;
          if (done === 1'b1) begin
            dones++;
            done_idx = idx;
            rdy_at_done = int'(cmd_ready);
          end
          if (done_idx >= 0 && idx == done_idx + 1) rdy_after = int'(cmd_ready);
          if (idx == abort_at) row_at_abort = int'(Row);
          idx++;
        end
      end
    end
  endtask

  initial begin
    int hits, stray, dones, didx, rdy_d, rdy_a, rab, d0;

    cols[0] = 4'b0111; cols[1] = 4'b1011; cols[2] = 4'b1101; cols[3] = 4'b1110;

    vecs[0]  = '{4'h1, 4'b0111, 4'b0111};
    vecs[1]  = '{4'h4, 4'b0111, 4'b1011};
    vecs[2]  = '{4'h7, 4'b0111, 4'b1101};
    vecs[3]  = '{4'h0, 4'b0111, 4'b1110};
    vecs[4]  = '{4'h2, 4'b1011, 4'b0111};
    vecs[5]  = '{4'h5, 4'b1011, 4'b1011};
    vecs[6]  = '{4'h8, 4'b1011, 4'b1101};
    vecs[7]  = '{4'hF, 4'b1011, 4'b1110};
    vecs[8]  = '{4'h3, 4'b1101, 4'b0111};
    vecs[9]  = '{4'h6, 4'b1101, 4'b1011};
    vecs[10] = '{4'h9, 4'b1101, 4'b1101};
    vecs[11] = '{4'hE, 4'b1101, 4'b1110};
    vecs[12] = '{4'hA, 4'b1110, 4'b0111};
    vecs[13] = '{4'hB, 4'b1110, 4'b1011};
    vecs[14] = '{4'hC, 4'b1110, 4'b1101};
    vecs[15] = '{4'hD, 4'b1110, 4'b1110};
    vecs[16] = '{4'h5, 4'b0111, 4'b1111};
    vecs[17] = '{4'hA, 4'b1011, 4'b1111};
    vecs[18] = '{4'h2, 4'b1111, 4'b1111};
    vecs[19] = '{4'h2, 4'b0011, 4'b1111};
    vecs[20] = '{4'h2, 4'b0000, 4'b1111};
    vecs[21] = '{4'h0, 4'b1110, 4'b1111};

    rst_n = 1'b0; Col = 4'b1111; key = '0; hold = '0; cmd_valid = 1'b0; abort = 1'b0;
    tick(); tick();
    check_val("rst_row", int'(Row), 4'b1111);
    check_val("rst_ready", int'(cmd_ready), 1);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    rst_n = 1'b1;
    tick();

    // Key map and non-one-hot Col handling, one press per vector.
    for (int i = 0; i < 22; i++) begin
      press_cmd(vecs[i].key, 8'd255, 4'b1111);
      Col = vecs[i].col;
      tick();
      check_val($sformatf("map_k%0h_c%b", vecs[i].key, vecs[i].col), int'(Row), int'(vecs[i].row));
      abort_release($sformatf("vec%0d", i));
    end

    // key 5, hold 3: three frames pressed, two released, then done.
    press_cmd(4'h5, 8'd3, 4'b1110);
    run_scan(7, 4'b1011, 4'b1011, -1, hits, stray, dones, didx, rdy_d, rdy_a, rab);
    check_val("h3_hits", hits, 24);
    check_val("h3_stray", stray, 0);
    check_val("h3_dones", dones, 1);
    check_val("h3_done_idx", didx, 160);
    check_val("h3_rdy_at_done", rdy_d, 0);
    check_val("h3_rdy_after", rdy_a, 1);

    // key 0 with hold 0 and hold 1: one frame, only while Col = 0111.
    for (int h = 0; h < 2; h++) begin
      press_cmd(4'h0, 8'(h), 4'b1110);
      run_scan(5, 4'b0111, 4'b1110, -1, hits, stray, dones, didx, rdy_d, rdy_a, rab);
      check_val($sformatf("h%0d_hits", h), hits, 8);
      check_val($sformatf("h%0d_stray", h), stray, 0);
      check_val($sformatf("h%0d_done_idx", h), didx, 96);
      check_val($sformatf("h%0d_rdy_after", h), rdy_a, 1);
    end

    // Abort midway through a hold=10 press.
    press_cmd(4'h5, 8'd10, 4'b1110);
    run_scan(5, 4'b1011, 4'b1011, 75, hits, stray, dones, didx, rdy_d, rdy_a, rab);
    check_val("ab_hits", hits, 19);
    check_val("ab_stray", stray, 0);
    check_val("ab_row", rab, 4'b1111);
    check_val("ab_dones", dones, 1);
    check_val("ab_done_idx", didx, 128);
    check_val("ab_rdy_after", rdy_a, 1);

    // Reset during a press: immediate release, no done, new command works.
    press_cmd(4'h5, 8'd10, 4'b1111);
    Col = 4'b1011;
    tick();
    check_val("rp_row_pressed", int'(Row), 4'b1011);
    d0 = done_total;
    rst_n = 1'b0;
    tick();
    check_val("rp_row", int'(Row), 4'b1111);
    check_val("rp_ready", int'(cmd_ready), 1);
    check_val("rp_busy", int'(busy), 0);
    rst_n = 1'b1;
    Col = 4'b0111; tick();
    Col = 4'b1011; tick();
    Col = 4'b0111; tick();
    Col = 4'b1111; tick();
    check_val("rp_no_done", done_total - d0, 0);
    press_cmd(4'h2, 8'd1, 4'b1111);
    Col = 4'b1011;
    tick();
    check_val("rp_new_row", int'(Row), 4'b0111);
    abort_release("rp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
